// File: rtl/difftest_pkg.sv
// Shared types for the difftest commit scheduler: commit record, FSM states
// and the commit-bit popcount helper.
package difftest_pkg;

  localparam int unsigned MAX_PORTS = 4;
  localparam int unsigned KCNT_W    = 3;

  typedef struct packed {
    logic        commit;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        rf_wen;
    logic [4:0]  wdest;
    logic [63:0] wdata;
  } difftest_info_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } sched_state_e;

  function automatic logic [KCNT_W-1:0] popcount_commit(input logic [MAX_PORTS-1:0] v);
    logic [KCNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(MAX_PORTS); i++) begin
      n = n + KCNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/difftest_commit_fifo.sv
// Circular buffer accepting up to NR_COMMIT_PORTS contiguous writes per cycle
// and one read; the head entry is presented combinationally.
module difftest_commit_fifo
  import difftest_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 16,
  localparam int unsigned CNT_W          = $clog2(DEPTH + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NR_COMMIT_PORTS-1:0] wr_en_i,
  input  difftest_info_t             wr_data_i [NR_COMMIT_PORTS],
  input  logic                       rd_en_i,
  output difftest_info_t             rd_data_o,
  output logic [CNT_W-1:0]           count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  difftest_info_t     mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [KCNT_W-1:0]  nwr;

  // Writes are packed from lane 0 upwards, so the lane count is the advance.
  assign nwr = popcount_commit(MAX_PORTS'(wr_en_i));

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(nwr);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_en_i);
    count_d  = count_q + CNT_W'(nwr) - CNT_W'(rd_en_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int j = 0; j < int'(NR_COMMIT_PORTS); j++) begin
      if (wr_en_i[j]) begin
        mem[wr_ptr_q + PTR_W'(j)] <= wr_data_i[j];
      end
    end
  end

  assign rd_data_o = mem[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/difftest_commit_sched.sv
// Compacts per-cycle commit slots into an in-order FIFO, drains it to the
// difftest checker and runs the halt/drain/done sequence.
module difftest_commit_sched
  import difftest_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 16
) (
  input  logic           clock,
  input  logic           reset,
  input  difftest_info_t diff_info [NR_COMMIT_PORTS],
  output logic           in_ready,
  input  logic           halt_req,
  output logic           out_valid,
  output difftest_info_t out_info,
  input  logic           out_ready,
  output logic [63:0]    commit_cnt,
  output logic           overflow,
  output logic           done
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  sched_state_e               state_q, state_d;
  logic                       in_ready_q, done_q, overflow_q, overflow_d;
  logic [63:0]                commit_cnt_q, commit_cnt_d;
  logic [MAX_PORTS-1:0]       commit_vec;
  logic [KCNT_W-1:0]          k;
  logic [KCNT_W-1:0]          ofs [NR_COMMIT_PORTS];
  logic [CNT_W-1:0]           count, count_d, free;
  logic                       accept, pop;
  logic [NR_COMMIT_PORTS-1:0] wr_en;
  difftest_info_t             wr_data [NR_COMMIT_PORTS];
  difftest_info_t             head;

  // Prefix sum: a valid port lands at offset = number of valid ports below it.
  always_comb begin
    logic [KCNT_W-1:0] run;
    run        = '0;
    commit_vec = '0;
    for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
      commit_vec[i] = diff_info[i].commit;
      ofs[i]        = run;
      run           = run + KCNT_W'(diff_info[i].commit);
    end
  end

  assign k      = popcount_commit(commit_vec);
  assign free   = CNT_W'(DEPTH) - count;
  assign accept = (state_q == RUN) && (k != '0) && (free >= CNT_W'(k));

  always_comb begin
    wr_en = '0;
    for (int j = 0; j < int'(NR_COMMIT_PORTS); j++) begin
      wr_data[j] = '0;
      for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
        if (diff_info[i].commit && (ofs[i] == KCNT_W'(j))) begin
          wr_en[j]   = accept;
          wr_data[j] = diff_info[i];
        end
      end
    end
  end

  difftest_commit_fifo #(
    .NR_COMMIT_PORTS(NR_COMMIT_PORTS),
    .DEPTH          (DEPTH)
  ) u_fifo (
    .clk_i    (clock),
    .rst_i    (reset),
    .wr_en_i  (wr_en),
    .wr_data_i(wr_data),
    .rd_en_i  (pop),
    .rd_data_o(head),
    .count_o  (count)
  );

  assign out_valid = (count != '0) && (state_q != DONE);
  assign out_info  = out_valid ? head : '0;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d      = state_q;
    overflow_d   = overflow_q;
    commit_cnt_d = commit_cnt_q + 64'(pop);
    count_d      = count - CNT_W'(pop);
    if (accept) begin
      count_d = count_d + CNT_W'(k);
    end
    // Any commit that is not accepted is lost to the checker.
    if ((k != '0) && !accept) begin
      overflow_d = 1'b1;
    end
    unique case (state_q)
      RUN:     if (halt_req) state_d = DRAIN;
      DRAIN:   if ((count == '0) || ((count == CNT_W'(1)) && pop)) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      in_ready_q   <= 1'b1;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      commit_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= (state_d == RUN) && ((CNT_W'(DEPTH) - count_d) >= CNT_W'(NR_COMMIT_PORTS));
      done_q       <= (state_d == DONE);
      overflow_q   <= overflow_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign commit_cnt = commit_cnt_q;

endmodule

// File: tb/tb_difftest_commit_sched.sv
// Directed self-checking bench for difftest_commit_sched (NR=2, DEPTH=16).
module tb_difftest_commit_sched;
  import difftest_pkg::*;

  localparam int unsigned NR    = 2;
  localparam int unsigned DEPTH = 16;

  logic           clock = 1'b0;
  logic           reset;
  difftest_info_t diff_info [NR];
  logic           in_ready;
  logic           halt_req;
  logic           out_valid;
  difftest_info_t out_info;
  logic           out_ready;
  logic [63:0]    commit_cnt;
  logic           overflow;
  logic           done;

  int vectors     = 0;
  int miscompares = 0;

  difftest_commit_sched #(.NR_COMMIT_PORTS(NR), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .diff_info (diff_info),
    .in_ready  (in_ready),
    .halt_req  (halt_req),
    .out_valid (out_valid),
    .out_info  (out_info),
    .out_ready (out_ready),
    .commit_cnt(commit_cnt),
    .overflow  (overflow),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic difftest_info_t mk(input logic c, input logic [63:0] pc);
    difftest_info_t t;
    t        = '0;
    t.commit = c;
    t.pc     = pc;
    t.instr  = pc[31:0] ^ 32'h0000_0013;
    t.wdata  = ~pc;
    return t;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input difftest_info_t a, input difftest_info_t b);
    diff_info[0] = a;
    diff_info[1] = b;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    halt_req  = 1'b0;
    out_ready = 1'b0;
    drive(mk(1'b0, 64'h0), mk(1'b0, 64'h0));
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_commit_cnt", commit_cnt, 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out_info", out_info.pc, 64'd0);
    reset = 1'b0;

    // 1: idle with no commits
    out_ready = 1'b1;
    repeat (10) tick();
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_commit_cnt", commit_cnt, 64'd0);

    // 2: two commits in one cycle come out in port order
    drive(mk(1'b1, 64'h8000_0000), mk(1'b1, 64'h8000_0004));
    tick();
    drive(mk(1'b0, 64'h0), mk(1'b0, 64'h0));
    chk("two_valid_n1", 64'(out_valid), 64'd1);
    chk("two_pc_a", out_info.pc, 64'h8000_0000);
    tick();
    chk("two_pc_b", out_info.pc, 64'h8000_0004);
    chk("two_cnt_1", commit_cnt, 64'd1);
    tick();
    chk("two_valid_end", 64'(out_valid), 64'd0);
    chk("two_cnt_2", commit_cnt, 64'd2);

    // 3: gap on port 0 is squeezed out
    drive(mk(1'b0, 64'hdead_0000), mk(1'b1, 64'h8000_0100));
    tick();
    drive(mk(1'b0, 64'h0), mk(1'b0, 64'h0));
    chk("gap_pc_c", out_info.pc, 64'h8000_0100);
    chk("gap_instr", 64'(out_info.instr), 64'h8000_0113);
    tick();
    chk("gap_no_bubble", 64'(out_valid), 64'd0);
    chk("gap_cnt", commit_cnt, 64'd3);

    // 4: backpressure until 15 entries, then a dropped group
    out_ready = 1'b0;
    drive(mk(1'b1, 64'h1000), mk(1'b0, 64'h0));
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(mk(1'b1, 64'h1004 + 64'(8 * i)), mk(1'b1, 64'h1008 + 64'(8 * i)));
      tick();
    end
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_no_ovf", 64'(overflow), 64'd0);
    drive(mk(1'b1, 64'hbad0), mk(1'b1, 64'hbad4));
    tick();
    drive(mk(1'b0, 64'h0), mk(1'b0, 64'h0));
    chk("drop_ovf", 64'(overflow), 64'd1);
    chk("drop_in_ready", 64'(in_ready), 64'd0);
    chk("stall_head", out_info.pc, 64'h1000);
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk("drain4_pc", out_info.pc, 64'h1000 + 64'(4 * i));
      tick();
      if (i == 0) chk("drain4_in_ready", 64'(in_ready), 64'd1);
    end
    chk("drain4_empty", 64'(out_valid), 64'd0);
    chk("drain4_cnt", commit_cnt, 64'd18);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // 5: fill to 14, halt with 2 more commits, drain to done
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(mk(1'b1, 64'h2000 + 64'(8 * i)), mk(1'b1, 64'h2004 + 64'(8 * i)));
      tick();
    end
    chk("fill14_in_ready", 64'(in_ready), 64'd1);
    drive(mk(1'b1, 64'h2038), mk(1'b1, 64'h203c));
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    drive(mk(1'b0, 64'h0), mk(1'b0, 64'h0));
    chk("halt_in_ready", 64'(in_ready), 64'd0);
    chk("halt_done", 64'(done), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain5_pc", out_info.pc, 64'h2000 + 64'(4 * i));
      chk("drain5_not_done", 64'(done), 64'd0);
      tick();
    end
    chk("done_set", 64'(done), 64'd1);
    chk("done_out_valid", 64'(out_valid), 64'd0);
    chk("done_cnt", commit_cnt, 64'd34);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("done_sticky", 64'(done), 64'd1);

    // 6: async reset mid-operation with 7 entries queued
    reset = 1'b1;
    #1;
    chk("rst2_done", 64'(done), 64'd0);
    chk("rst2_overflow", 64'(overflow), 64'd0);
    reset = 1'b0;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(mk(1'b1, 64'h3000 + 64'(8 * i)), mk(1'b1, 64'h3004 + 64'(8 * i)));
      tick();
    end
    drive(mk(1'b0, 64'h0), mk(1'b0, 64'h0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pre_rst_cnt", commit_cnt, 64'd1);
    chk("pre_rst_pc", out_info.pc, 64'h3004);
    #2;
    reset = 1'b1;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_cnt", commit_cnt, 64'd0);
    chk("async_in_ready", 64'(in_ready), 64'd1);
    chk("async_out_info", out_info.pc, 64'd0);
    reset = 1'b0;
    tick();
    drive(mk(1'b0, 64'h0), mk(1'b1, 64'h4000));
    tick();
    drive(mk(1'b0, 64'h0), mk(1'b0, 64'h0));
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_pc", out_info.pc, 64'h4000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
